core_sequencer: RTL and testbench

//   Multi-cycle control FSM for the RV32I core. Owns the PC and instruction register.

---
 rtl/core_sequencer_if.sv | 28 ++
 rtl/core_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_core_sequencer.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_sequencer_if.sv
// Shared memory port between the core sequencer (master) and the memory (slave).
// One request at a time; the master holds req/we/addr/wdata until ack.
interface core_sequencer_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle RV32I control FSM: owns PC/IR, runs the memory handshake, strobes writeback.
// Optional feature macro: MISALIGN_TRAP_EN (sticky trap on misaligned taken control transfer).
module core_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     is_load,
    input  logic                     is_store,
    input  logic                     is_branch,
    input  logic                     is_jal,
    input  logic                     is_jalr,
    input  logic                     branch_taken,
    input  logic [31:0]              alu_result,
    input  logic [31:0]              alu_address,
    input  logic [31:0]              rs2_val,
    core_sequencer_if.master         mem,
    output logic [2:0]               state,
    output logic [31:0]              pc,
    output logic [31:0]              instr,
    output logic                     rf_we,
    output logic [31:0]              rf_wdata,
    output logic                     retire,
    output logic                     trap
);

    typedef enum logic [2:0] {
        StReset     = 3'd0,
        StFetch     = 3'd1,
        StFetchWait = 3'd2,
        StDecode    = 3'd3,
        StRegRead   = 3'd4,
        StExecute   = 3'd5,
        StMemory    = 3'd6,
        StWriteback = 3'd7
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        rf_we_q, rf_we_d;
    logic [31:0] rf_wdata_q, rf_wdata_d;
    logic        retire_q, retire_d;
    logic        trap_q, trap_d;
    logic [31:0] tgt_q, tgt_d;
    logic        xfer_q, xfer_d;

    logic [31:0] target;
    logic [31:0] target_fix;
    logic        xfer;
    logic        misalign;

    assign target = is_jalr ? {alu_address[31:1], 1'b0} : alu_address;
    assign xfer   = is_jal | is_jalr | (is_branch & branch_taken);

`ifdef MISALIGN_TRAP_EN
    assign misalign   = xfer && (target[1:0] != 2'b00);
    assign target_fix = target;
`else
    assign misalign   = 1'b0;
    assign target_fix = target & 32'hFFFF_FFFC;
`endif

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rf_wdata_d  = rf_wdata_q;
        trap_d      = trap_q;
        tgt_d       = tgt_q;
        xfer_d      = xfer_q;

        unique case (state_q)
            StReset: begin
                // A latched trap parks the core here until reset.
                if (!trap_q) begin
                    state_d    = StFetch;
                    mem_addr_d = pc_q;
                end
            end
            StFetch, StFetchWait: begin
                if (mem.mem_ack) begin
                    instr_d = mem.mem_rdata;
                    state_d = StDecode;
                end else begin
                    state_d = StFetchWait;
                end
            end
            StDecode:  state_d = StRegRead;
            StRegRead: state_d = StExecute;
            StExecute: begin
                tgt_d  = target_fix;
                xfer_d = xfer;
                if (misalign) begin
                    trap_d  = 1'b1;
                    state_d = StReset;
                end else if (is_load || is_store) begin
                    state_d     = StMemory;
                    mem_addr_d  = alu_result;
                    mem_wdata_d = rs2_val;
                end else begin
                    state_d    = StWriteback;
                    rf_wdata_d = alu_result;
                end
            end
            StMemory: begin
                if (mem.mem_ack) begin
                    if (is_load) begin
                        rf_wdata_d = mem.mem_rdata;
                    end
                    state_d = StWriteback;
                end
            end
            StWriteback: begin
                pc_d       = xfer_q ? tgt_q : pc_q + 32'd4;
                mem_addr_d = pc_d;
                state_d    = StFetch;
            end
            default: state_d = StReset;
        endcase

        // Request/strobe registers are loaded from the next state so they line up with it.
        mem_req_d = (state_d == StFetch) || (state_d == StFetchWait) || (state_d == StMemory);
        mem_we_d  = (state_d == StMemory) && is_store;
        rf_we_d   = (state_d == StWriteback) && !is_store && !is_branch &&
                    (instr_q[11:7] != 5'd0);
        retire_d  = (state_d == StWriteback);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StReset;
            pc_q        <= RESET_PC;
            instr_q     <= 32'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            rf_we_q     <= 1'b0;
            rf_wdata_q  <= 32'd0;
            retire_q    <= 1'b0;
            trap_q      <= 1'b0;
            tgt_q       <= 32'd0;
            xfer_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rf_we_q     <= rf_we_d;
            rf_wdata_q  <= rf_wdata_d;
            retire_q    <= retire_d;
            trap_q      <= trap_d;
            tgt_q       <= tgt_d;
            xfer_q      <= xfer_d;
        end
    end

    assign state         = state_q;
    assign pc            = pc_q;
    assign instr         = instr_q;
    assign rf_we         = rf_we_q;
    assign rf_wdata      = rf_wdata_q;
    assign retire        = retire_q;
    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;

`ifdef MISALIGN_TRAP_EN
    assign trap = trap_q;
`else
    assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: an instruction table driven through a memory model,
// plus hand sequences for reset, misaligned jump and reset during a fetch wait.
module tb_core_sequencer;

    logic        clk;
    logic        rst_n;
    logic        is_load, is_store, is_branch, is_jal, is_jalr, branch_taken;
    logic [31:0] alu_result, alu_address, rs2_val;
    logic [2:0]  state;
    logic [31:0] pc, instr, rf_wdata;
    logic        rf_we, retire, trap;

    core_sequencer_if mem_bus ();

    core_sequencer #(
        .RESET_PC (32'h0000_0100)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .is_load      (is_load),
        .is_store     (is_store),
        .is_branch    (is_branch),
        .is_jal       (is_jal),
        .is_jalr      (is_jalr),
        .branch_taken (branch_taken),
        .alu_result   (alu_result),
        .alu_address  (alu_address),
        .rs2_val      (rs2_val),
        .mem          (mem_bus.master),
        .state        (state),
        .pc           (pc),
        .instr        (instr),
        .rf_we        (rf_we),
        .rf_wdata     (rf_wdata),
        .retire       (retire),
        .trap         (trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] ins;
        logic        ld, st, br, jal, jalr, taken;
        logic [31:0] ares, aaddr, rs2, rdata;
        int          fwait, mwait;
        logic [31:0] exp_pc;
        logic        exp_we;
        logic [31:0] exp_wdata;
        int          exp_lat;
    } vec_t;

    int total = 0;
    int bad   = 0;
    logic [2:0] trace[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input logic [31:0] ins,
                                input logic ld, input logic st, input logic br,
                                input logic jal, input logic jalr, input logic taken,
                                input logic [31:0] ares, input logic [31:0] aaddr,
                                input logic [31:0] rs2, input logic [31:0] rdata,
                                input int fwait, input int mwait, input logic [31:0] exp_pc,
                                input logic exp_we, input logic [31:0] exp_wdata,
                                input int exp_lat);
        vec_t v;
        v.name = n;    v.ins = ins;
        v.ld = ld;     v.st = st;     v.br = br;
        v.jal = jal;   v.jalr = jalr; v.taken = taken;
        v.ares = ares; v.aaddr = aaddr; v.rs2 = rs2; v.rdata = rdata;
        v.fwait = fwait; v.mwait = mwait;
        v.exp_pc = exp_pc; v.exp_we = exp_we; v.exp_wdata = exp_wdata; v.exp_lat = exp_lat;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        is_load = v.ld;  is_store = v.st; is_branch = v.br;
        is_jal = v.jal;  is_jalr = v.jalr; branch_taken = v.taken;
        alu_result = v.ares; alu_address = v.aaddr; rs2_val = v.rs2;
    endtask

    // Called at a negedge in FETCH; returns at the negedge of the following FETCH.
    task automatic run_instr(input vec_t v);
        int          cyc = 0;
        int          fw = 0;
        int          mw = 0;
        int          we_cnt = 0;
        logic [31:0] we_data = 32'd0;
        logic [31:0] start_pc = pc;
        bit          done = 0;
        drive(v);
        trace.delete();
        while (!done && cyc < 60) begin
            cyc++;
            trace.push_back(state);
            mem_bus.mem_ack = 1'b0;
            case (state)
                3'd1, 3'd2: begin
                    check({v.name, " fetch req"}, {31'd0, mem_bus.mem_req}, 32'd1);
                    check({v.name, " fetch addr"}, mem_bus.mem_addr, start_pc);
                    check({v.name, " fetch we"}, {31'd0, mem_bus.mem_we}, 32'd0);
                    if (fw == v.fwait) begin
                        mem_bus.mem_ack   = 1'b1;
                        mem_bus.mem_rdata = v.ins;
                    end
                    fw++;
                end
                3'd6: begin
                    check({v.name, " mem req"}, {31'd0, mem_bus.mem_req}, 32'd1);
                    check({v.name, " mem addr"}, mem_bus.mem_addr, v.ares);
                    check({v.name, " mem we"}, {31'd0, mem_bus.mem_we}, {31'd0, v.st});
                    if (v.st) check({v.name, " mem wdata"}, mem_bus.mem_wdata, v.rs2);
                    if (mw == v.mwait) begin
                        mem_bus.mem_ack   = 1'b1;
                        mem_bus.mem_rdata = v.rdata;
                    end
                    mw++;
                end
                default: check({v.name, " idle req"}, {31'd0, mem_bus.mem_req}, 32'd0);
            endcase
            if (rf_we) begin
                we_cnt++;
                we_data = rf_wdata;
            end
            if (retire) begin
                // Latency counts the cycle that launches the fetch through the retire cycle.
                check({v.name, " latency"}, cyc + 1, v.exp_lat);
                done = 1;
            end
            @(negedge clk);
        end
        mem_bus.mem_ack = 1'b0;
        check({v.name, " retired"}, {31'd0, done}, 32'd1);
        check({v.name, " instr"}, instr, v.ins);
        check({v.name, " rf_we cycles"}, we_cnt, {31'd0, v.exp_we});
        if (v.exp_we) check({v.name, " rf_wdata"}, we_data, v.exp_wdata);
        check({v.name, " pc"}, pc, v.exp_pc);
        check({v.name, " next state"}, {29'd0, state}, 32'd1);
    endtask

    vec_t vecs[10];
    vec_t jal_v;

    initial begin
        //                 name      instr         ld st br jl jr tk ares          aaddr
        vecs[0] = mk("addi",   32'h0050_0093, 0, 0, 0, 0, 0, 0, 32'h5,        32'h0,
                     32'h0, 32'h0, 0, 0, 32'h0000_0104, 1, 32'h5, 6);
        vecs[1] = mk("lw",     32'h0000_2103, 1, 0, 0, 0, 0, 0, 32'h200,      32'h0,
                     32'h0, 32'hDEAD_BEEF, 2, 2, 32'h0000_0108, 1, 32'hDEAD_BEEF, 11);
        vecs[2] = mk("sw",     32'h0011_2023, 0, 1, 0, 0, 0, 0, 32'h300,      32'h0,
                     32'hCAFE_F00D, 32'h0, 0, 1, 32'h0000_010C, 0, 32'h0, 8);
        vecs[3] = mk("beq_t",  32'h0000_0063, 0, 0, 1, 0, 0, 1, 32'h0,        32'h0FF0,
                     32'h0, 32'h0, 0, 0, 32'h0000_0FF0, 0, 32'h0, 6);
        vecs[4] = mk("beq_nt", 32'h0000_0063, 0, 0, 1, 0, 0, 0, 32'h0,        32'h2000,
                     32'h0, 32'h0, 0, 0, 32'h0000_0FF4, 0, 32'h0, 6);
        vecs[5] = mk("addi_x0", 32'h0000_0013, 0, 0, 0, 0, 0, 0, 32'h7,       32'h0,
                     32'h0, 32'h0, 0, 0, 32'h0000_0FF8, 0, 32'h0, 6);
        vecs[6] = mk("jalr",   32'h0000_80E7, 0, 0, 0, 0, 1, 0, 32'hFFC,      32'h201,
                     32'h0, 32'h0, 3, 0, 32'h0000_0200, 1, 32'hFFC, 9);
        vecs[7] = mk("lw_x3",  32'h0000_2183, 1, 0, 0, 0, 0, 0, 32'h400,      32'h0,
                     32'h0, 32'h1234_5678, 1, 0, 32'h0000_0204, 1, 32'h1234_5678, 8);
        vecs[8] = mk("jal_top", 32'h0000_006F, 0, 0, 0, 1, 0, 0, 32'h0,       32'hFFFF_FFFC,
                     32'h0, 32'h0, 0, 0, 32'hFFFF_FFFC, 0, 32'h0, 6);
        vecs[9] = mk("addi_wrap", 32'h0050_0093, 0, 0, 0, 0, 0, 0, 32'h9,     32'h0,
                     32'h0, 32'h0, 0, 0, 32'h0000_0000, 1, 32'h9, 6);
        jal_v   = mk("jal_mis", 32'h0000_006F, 0, 0, 0, 1, 0, 0, 32'h0,       32'h0FF2,
                     32'h0, 32'h0, 0, 0, 32'h0000_0FF0, 0, 32'h0, 6);

        rst_n = 1'b0;
        mem_bus.mem_ack = 1'b0;
        mem_bus.mem_rdata = 32'd0;
        drive(vecs[0]);
        repeat (2) @(negedge clk);

        check("rst state", {29'd0, state}, 32'd0);
        check("rst pc", pc, 32'h100);
        check("rst instr", instr, 32'd0);
        check("rst mem_req", {31'd0, mem_bus.mem_req}, 32'd0);
        check("rst mem_addr", mem_bus.mem_addr, 32'd0);
        check("rst ctl", {28'd0, rf_we, retire, trap, mem_bus.mem_we}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("boot state", {29'd0, state}, 32'd1);
        check("boot mem_req", {31'd0, mem_bus.mem_req}, 32'd1);
        check("boot mem_addr", mem_bus.mem_addr, 32'h100);

        for (int i = 0; i < 10; i++) begin
            run_instr(vecs[i]);
            if (i == 0) begin
                check("addi trace len", trace.size(), 5);
                if (trace.size() == 5) begin
                    check("addi trace", {20'd0, trace[0], trace[1], trace[2], trace[3],
                                         trace[4]}, {20'd0, 3'd1, 3'd3, 3'd4, 3'd5, 3'd7});
                end
            end
        end

`ifdef MISALIGN_TRAP_EN
        begin
            logic [31:0] pc0 = pc;
            int          n = 0;
            drive(jal_v);
            while (!trap && n < 20) begin
                mem_bus.mem_ack   = (state == 3'd1 || state == 3'd2);
                mem_bus.mem_rdata = jal_v.ins;
                n++;
                @(negedge clk);
            end
            mem_bus.mem_ack = 1'b0;
            check("trap set", {31'd0, trap}, 32'd1);
            for (int k = 0; k < 4; k++) begin
                check("trap park state", {29'd0, state}, 32'd0);
                check("trap park pc", pc, pc0);
                check("trap park quiet", {30'd0, mem_bus.mem_req, retire}, 32'd0);
                @(negedge clk);
            end
        end
`else
        run_instr(jal_v);
        check("jal_mis trap", {31'd0, trap}, 32'd0);
`endif

        // Reset landing in FETCH_WAIT, followed by a stale ack.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst2 trap clear", {31'd0, trap}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst2 fetch", {29'd0, state}, 32'd1);
        @(negedge clk);
        check("rst2 fetch wait", {29'd0, state}, 32'd2);
        check("rst2 req held", {31'd0, mem_bus.mem_req}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst req drop", {31'd0, mem_bus.mem_req}, 32'd0);
        check("midrst state", {29'd0, state}, 32'd0);
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = 32'hBAD0_BAD0;
        rst_n = 1'b1;
        @(negedge clk);
        mem_bus.mem_ack = 1'b0;
        check("late ack state", {29'd0, state}, 32'd1);
        check("late ack instr", instr, 32'd0);
        check("refetch addr", mem_bus.mem_addr, 32'h100);
        @(negedge clk);
        check("refetch wait", {29'd0, state}, 32'd2);
        check("refetch instr", instr, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
